// File: rtl/fifo_drain_buf_if.sv
// Handshake bundle for fifo_drain_buf: FIFO read port on one side, valid/ready stream on the other.
`default_nettype none

interface fifo_drain_buf_if #(
  parameter int DATA_WIDTH = 5
) ();
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  // slave: the drain buffer itself; master: whoever drives the FIFO and consumes the stream
  modport slave (
    input  fifo_rdata,
    input  fifo_empty,
    input  out_ready,
    output fifo_rd_en,
    output out_valid,
    output out_data
  );

  modport master (
    output fifo_rdata,
    output fifo_empty,
    output out_ready,
    input  fifo_rd_en,
    input  out_valid,
    input  out_data
  );
endinterface

`default_nettype wire

// File: rtl/fifo_drain_buf.sv
// Two-entry drain buffer behind a combinational-read FIFO; out_ready never feeds fifo_rd_en.
// Keeps a wrapping count of delivered entries.
`default_nettype none

module fifo_drain_buf #(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 flush_i,
  fifo_drain_buf_if.slave           bus,
  output logic [1:0]                buf_count_o,
  output logic [CNT_WIDTH-1:0]      deliv_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

  logic push;
  logic pop;

  // Pop decision uses only registered state and FIFO status, cutting the ready->rd_en path
  assign push           = !bus.fifo_empty && !flush_i && !reset && (state_q != ST_FULL);
  assign bus.fifo_rd_en = push;
  assign bus.out_valid  = (state_q != ST_EMPTY) && !flush_i;
  assign bus.out_data   = slot0_q;
  assign pop            = bus.out_valid && bus.out_ready;

  assign buf_count_o = state_q;
  assign deliv_cnt_o = cnt_q;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;

    if (pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_ONE;
          slot0_d = bus.fifo_rdata;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          slot0_d = bus.fifo_rdata;
        end else if (push) begin
          state_d = ST_FULL;
          slot1_d = bus.fifo_rdata;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_ONE;
          slot0_d = slot1_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops buffered entries but keeps the delivery count
    if (flush_i) begin
      state_d = ST_EMPTY;
      slot0_d = '0;
      slot1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_buf.sv
// Scoreboard bench for fifo_drain_buf: FIFO model on the read side, expected-entry queue on the output.
`default_nettype none

module tb_fifo_drain_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  buf_count;
  logic [15:0] deliv_cnt;
  logic [1:0]  buf_count2;
  logic [1:0]  deliv_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] fmem [0:63];
  int         rd_ptr = 0;
  int         wr_ptr = 0;

  logic [4:0]  exp_q [$];
  logic [15:0] cnt_model = '0;

  fifo_drain_buf_if #(.DATA_WIDTH(5)) bus ();
  fifo_drain_buf_if #(.DATA_WIDTH(5)) bus2 ();

  fifo_drain_buf #(.DATA_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .bus         (bus),
    .buf_count_o (buf_count),
    .deliv_cnt_o (deliv_cnt)
  );

  fifo_drain_buf #(.DATA_WIDTH(5), .CNT_WIDTH(2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (1'b0),
    .bus         (bus2),
    .buf_count_o (buf_count2),
    .deliv_cnt_o (deliv_cnt2)
  );

  always #5 clk = ~clk;

  assign bus.fifo_empty  = (rd_ptr == wr_ptr);
  assign bus.fifo_rdata  = fmem[rd_ptr % 64];
  assign bus2.fifo_rdata = 5'd17;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  task automatic fifo_push(input logic [4:0] v);
    fmem[wr_ptr % 64] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: advances on rd_en, empties on flush
  initial begin
    forever begin
      @(posedge clk);
      if (flush && !reset) rd_ptr <= wr_ptr;
      else if (bus.fifo_rd_en) rd_ptr <= rd_ptr + 1;
    end
  end

  // Scoreboard / protocol monitor, sampled mid-cycle
  initial begin
    logic       prev_stall;
    logic [4:0] prev_data;
    logic [4:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        cnt_model  = '0;
        prev_stall = 1'b0;
      end else if (flush) begin
        check_val("flush_valid", 32'(bus.out_valid), 0);
        check_val("flush_rd_en", 32'(bus.fifo_rd_en), 0);
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        check_val("buf_count", 32'(buf_count), 32'(exp_q.size()));
        check_val("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        check_val("rd_en", 32'(bus.fifo_rd_en), 32'(!bus.fifo_empty && exp_q.size() < 2));
        check_val("deliv_cnt", 32'(deliv_cnt), 32'(cnt_model));
        if (prev_stall) check_val("stall_stable", 32'(bus.out_data), 32'(prev_data));
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check_val("spurious_out", 32'(bus.out_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_val("out_data", 32'(bus.out_data), 32'(e));
            cnt_model = cnt_model + 16'd1;
          end
        end
        if (bus.fifo_rd_en) exp_q.push_back(bus.fifo_rdata);
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
      end
    end
  end

  initial begin
    int          pulses;
    int          cyc;
    logic        done;
    logic [15:0] d0;
    logic [1:0]  cnt2;
    int          n2;
    logic        xfer;

    reset           = 1'b1;
    flush           = 1'b0;
    bus.out_ready   = 1'b1;
    bus2.fifo_empty = 1'b1;
    bus2.out_ready  = 1'b1;

    // Reset values, FIFO preloaded with 3,7,9
    step();
    fifo_push(5'd3); fifo_push(5'd7); fifo_push(5'd9);
    step();
    #1;
    check_val("rst_valid", 32'(bus.out_valid), 0);
    check_val("rst_data", 32'(bus.out_data), 0);
    check_val("rst_buf", 32'(buf_count), 0);
    check_val("rst_deliv", 32'(deliv_cnt), 0);
    check_val("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    step();
    reset = 1'b0;
    #1;
    check_val("fill_rd_en", 32'(bus.fifo_rd_en), 1);
    check_val("fill_valid0", 32'(bus.out_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check_val("t1_valid_run", 32'(bus.out_valid), 1);
    end
    step();
    step();
    #1;
    check_val("t1_deliv", 32'(deliv_cnt), 3);
    check_val("t1_empty", 32'(buf_count), 0);

    // Back-pressure: 1..4 with out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    fifo_push(5'd1); fifo_push(5'd2); fifo_push(5'd3); fifo_push(5'd4);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.fifo_rd_en) pulses++;
      step();
    end
    check_val("bp_pulses", 32'(pulses), 2);
    check_val("bp_full", 32'(buf_count), 2);
    check_val("bp_head", 32'(bus.out_data), 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val("bp_drain_valid", 32'(bus.out_valid), 1);
      step();
    end

    // Alternating ready while streaming 0..9
    d0 = deliv_cnt;
    for (int v = 0; v < 10; v++) fifo_push(5'(v));
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 60) begin
      bus.out_ready = ~bus.out_ready;
      step();
      #1;
      done = (rd_ptr == wr_ptr) && (buf_count == 2'd0);
      cyc++;
    end
    check_val("alt_drained", 32'(done), 1);
    check_val("alt_count", 32'(deliv_cnt - d0), 10);

    // Flush with a full buffer
    bus.out_ready = 1'b0;
    fifo_push(5'd20); fifo_push(5'd21); fifo_push(5'd22);
    cyc = 0;
    while (buf_count != 2'd2 && cyc < 10) begin
      step();
      cyc++;
    end
    check_val("fl_full", 32'(buf_count), 2);
    d0    = deliv_cnt;
    flush = 1'b1;
    #1;
    check_val("fl_valid", 32'(bus.out_valid), 0);
    check_val("fl_rd_en", 32'(bus.fifo_rd_en), 0);
    step();
    flush = 1'b0;
    #1;
    check_val("fl_buf", 32'(buf_count), 0);
    check_val("fl_data", 32'(bus.out_data), 0);
    check_val("fl_deliv", 32'(deliv_cnt), 32'(d0));

    // Reset while full with out_ready high
    fifo_push(5'd25); fifo_push(5'd26); fifo_push(5'd27);
    cyc = 0;
    while (buf_count != 2'd2 && cyc < 10) begin
      step();
      cyc++;
    end
    check_val("rs_full", 32'(buf_count), 2);
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    step();
    #1;
    check_val("rs_valid", 32'(bus.out_valid), 0);
    check_val("rs_data", 32'(bus.out_data), 0);
    check_val("rs_buf", 32'(buf_count), 0);
    check_val("rs_deliv", 32'(deliv_cnt), 0);
    check_val("rs_rd_en", 32'(bus.fifo_rd_en), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_val("rs_after", 32'(deliv_cnt), 1);

    // Narrow counter wrap on the second instance
    bus2.fifo_empty = 1'b0;
    cnt2 = 2'd0;
    n2   = 0;
    cyc  = 0;
    while (n2 < 5 && cyc < 20) begin
      @(negedge clk);
      xfer = bus2.out_valid && bus2.out_ready;
      step();
      if (xfer) begin
        cnt2 = cnt2 + 2'd1;
        check_val("wrap_cnt", 32'(deliv_cnt2), 32'(cnt2));
        n2++;
      end
      cyc++;
    end
    check_val("wrap_done", 32'(n2), 5);
    bus2.fifo_empty = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_drain_buf.md
# fifo_drain_buf

Read-side front end for the core's small synchronous FIFOs (free lists, tag queues). It pops entries from a FIFO with a combinational read port and a `rd_en`/`empty` interface, and holds them in a 2-entry buffer. It presents them downstream in order over a valid/ready handshake. Downstream `out_ready` never reaches the FIFO's `rd_en` combinationally, which breaks the timing path from the consumer stage back into the FIFO. The block also keeps a wrapping count of delivered entries for debug and perf.

## Interface
Parameters:
- `DATA_WIDTH`, default 5: entry width; must match the FIFO data width.
- `CNT_WIDTH`, default 16: width of the delivered-entry counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous pipeline flush, asserted in the same cycle as the upstream FIFO's flush.
- `fifo_rdata`  in  DATA_WIDTH  FIFO head entry, combinational from the FIFO.
- `fifo_empty`  in  1  FIFO has no entries.
- `fifo_rd_en`  out  1  pop request; the FIFO advances on the same edge.
- `out_valid`  out  1  `out_data` is valid.
- `out_data`  out  DATA_WIDTH  oldest buffered entry.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `buf_count`  out  2  entries held in the buffer (0..2).
- `deliv_cnt`  out  CNT_WIDTH  number of accepted transfers; wraps modulo 2^CNT_WIDTH.

## Operation
- Storage:
  - Two registers: `slot0` (head) and `slot1`.
  - A state register with states EMPTY, ONE and FULL, encoding 0, 1 and 2; `buf_count` equals the encoding.
- Control signals:
  - `fifo_rd_en = !fifo_empty & !flush & !reset & (state != FULL)`.
  - `fifo_rd_en` depends only on registered state and FIFO status, never on `out_ready`.
  - `push = fifo_rd_en`; the entry captured is `fifo_rdata` sampled at that edge.
  - `out_valid = (state != EMPTY) & !flush`.
  - `out_data = slot0`.
  - `pop = out_valid & out_ready`.
- Transitions when neither `reset` nor `flush` is asserted:
  - EMPTY, push → ONE; `slot0` ← rdata.
  - EMPTY, no push → EMPTY.
  - ONE, push & pop → ONE; `slot0` ← rdata.
  - ONE, push only → FULL; `slot1` ← rdata.
  - ONE, pop only → EMPTY.
  - ONE, neither → ONE.
  - FULL, pop → ONE; `slot0` ← `slot1`. No push is possible because `rd_en` is low in FULL.
  - FULL, no pop → FULL.
- Ordering: entries leave in exactly the order they were popped from the FIFO. No entry is lost or duplicated.
- `deliv_cnt` increments by 1 on every pop and wraps from all-ones to 0.
- Flush:
  - state ← EMPTY; `slot0` and `slot1` ← 0.
  - `deliv_cnt` is NOT cleared.
  - During the flush cycle, `out_valid` and `fifo_rd_en` are forced 0, so no transfer and no pop occur.
- Reset:
  - Clears state, both slots and `deliv_cnt` to 0.
  - Reset asserted mid-operation discards buffered entries in the same way.
  - Reset has priority over flush.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `buf_count` = 0, `deliv_cnt` = 0.
  - `fifo_rd_en` = 0 while `reset` is high.
- Fill latency: the FIFO becomes non-empty in cycle N. `fifo_rd_en` is high in cycle N, and `out_valid` is high in cycle N+1.
- Steady state: with the FIFO non-empty and `out_ready` held high, the block holds in ONE and delivers 1 entry/cycle with no bubbles.
- Back-pressure: with `out_ready` low, the buffer fills to FULL after 2 pops, and `fifo_rd_en` stays low until a pop occurs.
- After `out_ready` returns high, FULL drains to ONE in 1 cycle. `fifo_rd_en` re-asserts in that following cycle (state ONE), so throughput continues without a gap.
- `out_data` is stable while `out_valid & !out_ready`.

## Test plan
- Reset, then FIFO preloaded with 3, 7, 9 and `out_ready` = 1 → `out_valid` rises 1 cycle after reset deassert. Outputs 3, 7, 9 appear on consecutive cycles. `deliv_cnt` = 3, and the final state is EMPTY.
- FIFO holds 1, 2, 3, 4 and `out_ready` = 0 for 5 cycles → `fifo_rd_en` pulses exactly twice. `buf_count` = 2 and `out_data` = 1 held stable. After `out_ready` = 1, the outputs are 1, 2, 3, 4 in order with no gaps.
- Alternate `out_ready` 1/0 every cycle while the FIFO streams 0..9 → all 10 values arrive in order with no duplicates, and `buf_count` never exceeds 2.
- Flush in a cycle with `buf_count` = 2 → `out_valid` and `fifo_rd_en` are 0 in that cycle. Next cycle: `buf_count` = 0, `out_data` = 0, `deliv_cnt` unchanged.
- Reset asserted while FULL and `out_ready` = 1 → no transfer is counted, and all outputs return to their reset values next cycle.
- `CNT_WIDTH` = 2, 5 transfers → `deliv_cnt` reads 1, 2, 3, 0, 1.
